// File: rtl/i2c_reg_target.sv
// I2C write-only register target: 16-bit register / 16-bit value writes become one-cycle strobes.
// Define I2C_TGT_AUTOINC_EN to ACK further value pairs and write them to consecutive addresses.
module i2c_reg_target #(
  parameter logic [6:0] I2C_ADDR = 7'h0A,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        wr_stb,
  output logic        busy
);

`ifdef I2C_TGT_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_RX, ST_ACK, ST_IGNORE} state_t;

  // Index 0 = SCL, index 1 = SDA for the synchronizer/filter arrays.
  logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0] filt_q, filt_d, prev_q, prev_d;
  logic [2:0] cnt_q [2];
  logic [2:0] cnt_d [2];

  always_comb begin
    sync1_d = {sda_i, scl_i};
    sync2_d = sync1_q;
    prev_d  = filt_q;
    filt_d  = filt_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = 3'd0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == 3'(FILT_LEN - 1)) filt_d[i] = sync2_q[i];
        else cnt_d[i] = cnt_q[i] + 3'd1;
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  assign scl_f     = filt_q[0];
  assign sda_f     = filt_q[1];
  assign scl_rise  = scl_f & ~prev_q[0];
  assign scl_fall  = ~scl_f & prev_q[0];
  assign start_det = scl_f & prev_q[0] & prev_q[1] & ~sda_f;
  assign stop_det  = scl_f & prev_q[0] & ~prev_q[1] & sda_f;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d, byte_idx_q, byte_idx_d;
  logic        full_q, full_d, seq_q, seq_d, busy_q, busy_d;
  logic        stb_q, stb_d, oe_q, oe_d, ack;
  logic [7:0]  shift_q, shift_d, reg_hi_q, reg_hi_d, reg_lo_q, reg_lo_d, val_hi_q, val_hi_d;
  logic [15:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    full_d     = full_q;
    seq_d      = seq_q;
    busy_d     = busy_q;
    shift_d    = shift_q;
    reg_hi_d   = reg_hi_q;
    reg_lo_d   = reg_lo_q;
    val_hi_d   = val_hi_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    stb_d      = 1'b0;
    ack        = 1'b1;
    if (stop_det) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = 3'd0;
      byte_idx_d = 3'd0;
      full_d     = 1'b0;
      seq_d      = 1'b0;
      busy_d     = 1'b0;
    end else if (start_det) begin
      state_d    = ST_RX;
      bit_cnt_d  = 3'd0;
      byte_idx_d = 3'd0;
      full_d     = 1'b0;
      seq_d      = 1'b0;
    end else begin
      case (state_q)
        ST_RX: begin
          if (scl_rise && !full_q) begin
            shift_d   = {shift_q[6:0], sda_f};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) full_d = 1'b1;
          end else if (scl_fall && full_q) begin
            full_d = 1'b0;
            case (byte_idx_q)
              3'd0: begin
                ack    = (shift_q == {I2C_ADDR, 1'b0});
                busy_d = ack;
              end
              3'd1: reg_hi_d = shift_q;
              3'd2: reg_lo_d = shift_q;
              3'd3: val_hi_d = shift_q;
              3'd4: begin
                // A follow-on pair (auto-increment) targets the address after the last strobe.
                wr_addr_d = seq_q ? wr_addr_q + 16'd1 : {reg_hi_q, reg_lo_q};
                wr_data_d = {val_hi_q, shift_q};
                stb_d     = 1'b1;
                seq_d     = AUTOINC;
              end
              default: ack = 1'b0;
            endcase
            state_d = ack ? ST_ACK : ST_IGNORE;
          end
        end
        ST_ACK: begin
          if (scl_fall) begin
            state_d = ST_RX;
            if (byte_idx_q == 3'd4) byte_idx_d = AUTOINC ? 3'd3 : 3'd5;
            else byte_idx_d = byte_idx_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
    oe_d = (state_d == ST_ACK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      prev_q     <= 2'b11;
      cnt_q[0]   <= 3'd0;
      cnt_q[1]   <= 3'd0;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      byte_idx_q <= 3'd0;
      full_q     <= 1'b0;
      seq_q      <= 1'b0;
      busy_q     <= 1'b0;
      shift_q    <= 8'd0;
      reg_hi_q   <= 8'd0;
      reg_lo_q   <= 8'd0;
      val_hi_q   <= 8'd0;
      wr_addr_q  <= 16'd0;
      wr_data_q  <= 16'd0;
      stb_q      <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      filt_q     <= filt_d;
      prev_q     <= prev_d;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      full_q     <= full_d;
      seq_q      <= seq_d;
      busy_q     <= busy_d;
      shift_q    <= shift_d;
      reg_hi_q   <= reg_hi_d;
      reg_lo_q   <= reg_lo_d;
      val_hi_q   <= val_hi_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      stb_q      <= stb_d;
      oe_q       <= oe_d;
    end
  end

  assign sda_oe  = oe_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_stb  = stb_q;
  assign busy    = busy_q;

endmodule

// File: doc/i2c_reg_target.md
# i2c_reg_target

I2C target (slave) that receives the 16-bit-register / 16-bit-value write transactions our codec init master issues, and presents each completed write as a one-cycle strobe on a parallel register bus. It sits behind the shared open-drain SCL/SDA pins, with the IOB instantiated outside this block. Main uses: a loopback model of the codec for bench self-checking, and configuration of on-FPGA register banks by an external master. Write-only: read requests are NACKed.

## Interface
Parameters:
- `I2C_ADDR`, 7'h0A, 7-bit target address; matches address byte 8'h14 with R/W=0.
- `FILT_LEN`, 3, consecutive identical synchronized samples required before a filtered SCL/SDA level changes (1..7).

Ports:
- `clk`  in  1  system clock; all logic in this domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `scl_i`  in  1  raw SCL pin level (asynchronous).
- `sda_i`  in  1  raw SDA pin level (asynchronous).
- `sda_oe`  out  1  1 = pull SDA low (ACK); SDA output data is tied 0 externally.
- `wr_addr`  out  16  register address of the last completed write.
- `wr_data`  out  16  value of the last completed write.
- `wr_stb`  out  1  one-cycle pulse; `wr_addr`/`wr_data` are valid in the same cycle.
- `busy`  out  1  high from an addressed START until STOP.

## Operation
- Input path: 2-FF synchronizer per line, then a `FILT_LEN`-sample stability filter giving `scl_f`/`sda_f`. All edge detection uses the filtered signals.
- START: `sda_f` falls while `scl_f`=1. STOP: `sda_f` rises while `scl_f`=1. Both are detected in every state, take priority over bit sampling, and clear the bit and byte counters.
- Data bits are sampled MSB-first on `scl_f` rising edges; a 3-bit bit counter plus a byte index count 0..4.
- FSM states:
  - ST_IDLE: waits for START, then goes to ST_RX with byte index 0.
  - ST_RX: shifts 8 bits. On the 8th `scl_f` falling edge it decides ACK/NACK and goes to ST_ACK, or to ST_IGNORE on NACK.
  - ST_ACK: `sda_oe`=1 until the next `scl_f` falling edge, then back to ST_RX with byte index +1.
  - ST_IGNORE: `sda_oe`=0. Waits for STOP (to ST_IDLE) or START (to ST_RX).
- ACK rules:
  - Byte 0 is ACKed only if it equals {`I2C_ADDR`,1'b0}. A mismatch or R/W=1 goes to ST_IGNORE.
  - Bytes 1..4 are ACKed and form reg_hi, reg_lo, val_hi, val_lo.
- On the ACK decision for byte 4:
  - `wr_addr`={reg_hi,reg_lo} and `wr_data`={val_hi,val_lo} are loaded.
  - `wr_stb` pulses in the next cycle.
- Bytes beyond index 4 are handled according to the Configuration section.
- Repeated START mid-transaction discards any partial register/value bytes with no strobe.
- STOP mid-transaction discards the partial transaction and returns to ST_IDLE.
- `busy` rises on the byte-0 ACK decision and falls on STOP or on a START into a non-matching address.

## Timing
- Reset values: `sda_oe`=0, `wr_stb`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, state ST_IDLE, filters preset to 1 (bus idle).
- `rst_n` assertion releases `sda_oe` immediately, without waiting for a clock edge.
- Pin-to-filtered latency: 2 + `FILT_LEN` clk cycles.
- `sda_oe` changes 1 clk after the filtered `scl_f` falling edge, which satisfies SDA hold time given clk ≥ 8× SCL.
- `wr_stb` is exactly 1 clk wide and is never asserted in two consecutive cycles.
- `wr_addr`/`wr_data` hold their value until the next strobe.
- Minimum supported ratio: clk ≥ 8× SCL with `FILT_LEN`=3.

## Configuration
- `I2C_TGT_AUTOINC_EN` defined:
  - After byte 4, each further pair of bytes (val_hi, val_lo) is ACKed.
  - Each pair strobes a write to the previous `wr_addr`+1, wrapping 16'hFFFF→16'h0000.
- `I2C_TGT_AUTOINC_EN` undefined: byte 5 is NACKed and the FSM goes to ST_IGNORE; no further strobes until a new START.

## Test plan
- Write 0x14, 0x00, 0x30, 0x12, 0x34, then STOP → five ACKs; exactly one `wr_stb` with `wr_addr`=0x0030 and `wr_data`=0x1234; `busy` low after STOP.
- Address byte 0x16 (wrong address) and 0x15 (read) → `sda_oe` never asserted on any bit; no `wr_stb`; `busy` stays 0.
- 0x14, 0x00, 0x30, then STOP → no `wr_stb`; a following full write 0x14, 0x00, 0x40, 0xAB, 0xCD → strobe with 0x0040/0xABCD.
- 0x14, 0xFF, 0xFF, 0x11, 0x22, 0x33, 0x44:
  - with `I2C_TGT_AUTOINC_EN`: strobes 0xFFFF/0x1122, then 0x0000/0x3344;
  - without: one strobe, and byte 0x33 is NACKed.
- 1-clk glitches on SCL during a data bit plus a repeated START after the reg_lo byte → glitches ignored; partial transaction discarded; new transaction completes normally.
- Assert `rst_n`=0 while `sda_oe`=1 during an ACK → `sda_oe` drops with no clock edge; all outputs return to reset values; the next START is decoded correctly.
